icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache.
- Responder side of the fetch-to-icache interface (read_flag/addr in; read_data/busy/done out).
- Sits between the fetch stage and the instruction memory port. Serves hits in one cycle and refills whole lines on a miss through a word-serial memory handshake.
- Invalidated wholesale by a flush input (fence.i / program reload).

Parameters:
ADDR_WIDTH, 32, byte address and data width.
NUM_LINES, 64, number of cache lines; power of two.
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
read_flag  input  1  fetch request; sampled only when busy=0.
addr  input  ADDR_WIDTH  fetch byte address; addr[1:0] ignored.
read_data  output  ADDR_WIDTH  instruction word; valid only while done=1.
busy  output  1  cache is refilling; new requests are ignored.
done  output  1  one-cycle pulse; read_data is valid.
flush  input  1  invalidate all lines.
mem_read  output  1  memory word request.
mem_addr  output  ADDR_WIDTH  word-aligned memory address.
mem_rdata  input  ADDR_WIDTH  memory read data.
mem_valid  input  1  mem_rdata valid; completes one word transfer.

Behaviour:
- Address split (defaults):
  - offset = addr[3:2]
  - index = addr[9:4]
  - tag = addr[31:10] (22 bits)
  - Widths derive from the parameters via $clog2.
- Storage: data array NUM_LINES x LINE_WORDS x 32, tag array, valid bit per line.
- Reset (async, rst=1): all valid bits cleared; state=IDLE; busy=0, done=0, mem_read=0, mem_addr=0, read_data=0. Data and tag arrays are not reset.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - Request accepted at a posedge with read_flag=1. Address is latched (req_addr).
  - Hit (valid[index] and tag match): next cycle done=1 and read_data=word; state stays IDLE. Hit latency is 1 cycle.
  - Miss: next state REFILL, word counter=0.
  - A new request may be accepted in the same cycle done=1 is driven, giving back-to-back hits at 1 word/cycle.
- REFILL:
  - busy=1 and mem_read=1 continuously.
  - mem_addr = {req tag, req index, counter, 2'b00}.
  - On each posedge with mem_valid=1: write mem_rdata into data[index][counter], then increment counter.
  - When the last word (counter=LINE_WORDS-1) is accepted: write tag, set valid[index], go to RESPOND.
  - mem_read drops the cycle after the last mem_valid.
  - Refill always fills from word 0; there is no critical-word-first.
- RESPOND (one cycle):
  - busy=0, done=1, read_data = data[index][req offset].
  - read_flag is accepted in this cycle exactly as in IDLE.
  - Next state is IDLE, or the accept outcome.
- done is never high for two cycles for the same request. Each accepted request produces exactly one done.
- read_flag while busy=1 is ignored; no queuing.
- flush:
  - In IDLE or RESPOND: all valid bits cleared at that posedge. A read_flag in the same cycle is treated as a miss.
  - During REFILL: the refill completes and the word is delivered, but the line is left invalid. The flush is recorded and applied when refill finishes.
- Simultaneous mem_valid and flush on the last word: data is delivered, the line stays invalid.
- rst mid-refill: FSM aborts immediately; mem_read and busy fall asynchronously; the partial line remains invalid.
- mem_valid outside REFILL is ignored.

Test Plan:
- Reset, then read_flag=1, addr=0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 for words 0x40..0x4C (mem_valid one cycle after each request):
  - mem_addr sequence is 0x40, 0x44, 0x48, 0x4C.
  - busy=1 throughout the refill.
  - done=1 with read_data=0x11 one cycle after the last mem_valid.
- After that refill, requests at 0x44, 0x48, 0x4C on consecutive cycles: done=1 on the three following cycles with 0x22, 0x33, 0x44; mem_read stays 0.
- Conflict miss: addr 0x0000_0440 (same index, tag 1) triggers a refill. A subsequent request to 0x40 misses again and refills.
- Request at 0x4A (misaligned): returns word 0x48; no refill after the line is resident.
- flush pulse, then addr=0x40: miss and full refill.
- flush asserted mid-refill: done still arrives with the correct word, and the next request to the same line misses.
- rst asserted on the 2nd mem_valid: busy=0 and mem_read=0 immediately. A request after reset to the same line performs a full 4-word refill.

Source files
------------

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache.
//
// Serves fetch requests (read_flag/addr) with a one-cycle hit latency and
// refills whole lines on a miss through a word-serial memory handshake
// (mem_read/mem_addr out, mem_rdata/mem_valid in). A flush input invalidates
// every line; a flush that arrives mid-refill is held until the refill ends.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous, active-high reset
//   read_flag  fetch request, sampled only while busy=0
//   addr       fetch byte address (addr[1:0] ignored)
//   read_data  instruction word, valid while done=1
//   busy       refill in progress, new requests are ignored
//   done       one-cycle pulse per accepted request
//   flush      invalidate all lines
//   mem_read   memory word request (held for the whole refill)
//   mem_addr   word-aligned memory address
//   mem_rdata  memory read data
//   mem_valid  mem_rdata valid, completes one word transfer
// -----------------------------------------------------------------------------
module icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_flag,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    input  logic                  flush,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [ADDR_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] data_mem [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] cnt;
    logic             flush_pend;

    // Address split of the incoming request.
    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             unused_byte_bits;

    assign a_tag            = addr[ADDR_WIDTH-1 -: TAG_W];
    assign a_idx            = addr[OFF_W+2 +: IDX_W];
    assign a_off            = addr[2 +: OFF_W];
    assign unused_byte_bits = ^addr[1:0];

    logic accept, hit, last_beat;

    // RESPOND accepts a new request exactly like IDLE does.
    assign accept    = (state != REFILL) && read_flag;
    // A flush in the same cycle forces a miss.
    assign hit       = valid[a_idx] && (tag_mem[a_idx] == a_tag) && !flush;
    assign last_beat = (state == REFILL) && mem_valid && (cnt == OFF_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // busy/mem_read/mem_addr decode the state register directly, so they
    // drop as soon as rst asserts.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        state_next = state;
        busy       = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE, RESPOND: begin
                if (accept && !hit) state_next = REFILL;
                else                state_next = IDLE;
            end
            REFILL: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = {req_tag, req_idx, cnt, 2'b00};
                if (last_beat) state_next = RESPOND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            done       <= 1'b0;
            read_data  <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_off    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            done <= 1'b0;

            if (accept) begin
                req_tag <= a_tag;
                req_idx <= a_idx;
                req_off <= a_off;
                cnt     <= '0;
                if (hit) begin
                    done      <= 1'b1;
                    read_data <= data_mem[a_idx][a_off];
                end
            end

            if ((state != REFILL) && flush) valid <= '0;

            if (state == REFILL) begin
                if (flush) flush_pend <= 1'b1;
                if (mem_valid) begin
                    cnt <= cnt + 1'b1;
                    // Capture the requested word as it streams past so the
                    // RESPOND cycle needs no extra array read.
                    if (cnt == req_off) read_data <= mem_rdata;
                end
                if (last_beat) begin
                    done       <= 1'b1;
                    flush_pend <= 1'b0;
                    // A flush seen during the refill wins: the new line is
                    // delivered once but never becomes valid.
                    if (flush_pend || flush) valid <= '0;
                    else                     valid[req_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the data and tag arrays carry no reset; the valid bits alone
    // decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if ((state == REFILL) && mem_valid) data_mem[req_idx][cnt] <= mem_rdata;
        if (last_beat)                      tag_mem[req_idx]       <= req_tag;
    end

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache -- self-checking bench for icache.
//
// The memory is a pure function of the word address. A line-level model of
// the cache (valid/tag per line plus an "outstanding refill" record) predicts
// done/read_data/busy/mem_addr; a compare process checks the DUT against it
// on every falling edge. Directed scenarios add literal expectations, then a
// randomized phase exercises hits, misses, conflicts and flushes.
// -----------------------------------------------------------------------------
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_flag = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        flush = 1'b0;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .read_flag (read_flag),
        .addr      (addr),
        .read_data (read_data),
        .busy      (busy),
        .done      (done),
        .flush     (flush),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: words 0x40..0x4C hold 0x11..0x44, everything else a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h4) return 32'h11 * ({30'd0, w[3:2]} + 32'd1);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // ---------------- line-level model ----------------
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    bit          m_refill;
    bit          m_flush;
    logic [31:0] m_line;
    logic [31:0] m_req;
    int          m_words;

    logic        exp_done  = 1'b0;
    logic [31:0] exp_data  = '0;
    logic        exp_busy  = 1'b0;
    logic [31:0] exp_maddr = '0;
    bit          chk_en    = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_refill = 1'b0;
        m_flush  = 1'b0;
        m_words  = 0;
        m_line   = '0;
        exp_done = 1'b0;
        exp_busy = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, update the model with the
    // values the DUT samples at the rising edge, return at the next falling edge.
    task automatic cycle(input logic rf, input logic [31:0] a, input logic fl, input logic mv);
        int idx;
        read_flag = rf;
        addr      = a;
        flush     = fl;
        mem_valid = mv;
        mem_rdata = mem_word(mem_addr);
        @(posedge clk);
        exp_done = 1'b0;
        if (!m_refill) begin
            if (fl) for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            if (rf) begin
                idx = int'(a[9:4]);
                if (!fl && m_valid[idx] && m_tag[idx] == a[31:10]) begin
                    exp_done = 1'b1;
                    exp_data = mem_word(a);
                end else begin
                    m_refill = 1'b1;
                    m_flush  = 1'b0;
                    m_words  = 0;
                    m_line   = {a[31:4], 4'h0};
                    m_req    = a;
                end
            end
        end else begin
            if (fl) m_flush = 1'b1;
            if (mv) begin
                m_words++;
                if (m_words == 4) begin
                    m_refill = 1'b0;
                    exp_done = 1'b1;
                    exp_data = mem_word(m_req);
                    if (m_flush) for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
                    else begin
                        m_valid[int'(m_line[9:4])] = 1'b1;
                        m_tag[int'(m_line[9:4])]   = m_line[31:10];
                    end
                end
            end
        end
        exp_busy  = m_refill;
        exp_maddr = m_line + 32'(4 * m_words);
        @(negedge clk);
    endtask

    // Feed mem_valid every cycle until the model says the refill is over.
    task automatic run_refill(output int beats);
        beats = 0;
        for (int i = 0; i < 40 && exp_busy; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            beats++;
        end
        check("refill ends", {31'd0, busy}, 32'd0);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("done", {31'd0, done}, {31'd0, exp_done});
            if (exp_done) check("read_data", read_data, exp_data);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("mem_read", {31'd0, mem_read}, {31'd0, exp_busy});
            if (exp_busy) check("mem_addr", mem_addr, exp_maddr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    logic [31:0] t1_addrs [4];
    int          beats;

    initial begin
        t1_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset busy",      {31'd0, busy},     32'd0);
        check("reset done",      {31'd0, done},     32'd0);
        check("reset mem_read",  {31'd0, mem_read}, 32'd0);
        check("reset mem_addr",  mem_addr,          32'd0);
        check("reset read_data", read_data,         32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: cold miss at 0x40, mem_valid one cycle after each request.
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t1 busy", {31'd0, busy}, 32'd1);
            check("t1 mem_addr", mem_addr, t1_addrs[k]);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            check("t1 busy gap", {31'd0, busy}, 32'd1);
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        check("t1 done", {31'd0, done}, 32'd1);
        check("t1 data", read_data, 32'h11);

        // 2: back-to-back hits on the resident line.
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        check("t2 data0", read_data, 32'h22);
        cycle(1'b1, 32'h48, 1'b0, 1'b0);
        check("t2 data1", read_data, 32'h33);
        cycle(1'b1, 32'h4C, 1'b0, 1'b0);
        check("t2 data2", read_data, 32'h44);
        check("t2 mem_read", {31'd0, mem_read}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // 3: conflict miss, then the original line misses again.
        cycle(1'b1, 32'h440, 1'b0, 1'b0);
        check("t3 miss 0x440", {31'd0, busy}, 32'd1);
        run_refill(beats);
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        check("t3 miss 0x40", {31'd0, busy}, 32'd1);
        run_refill(beats);
        check("t3 data", read_data, 32'h11);

        // 4: misaligned address hits word 0x48.
        cycle(1'b1, 32'h4A, 1'b0, 1'b0);
        check("t4 done", {31'd0, done}, 32'd1);
        check("t4 data", read_data, 32'h33);
        check("t4 no refill", {31'd0, busy}, 32'd0);

        // 5: flush pulse, then full refill.
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        check("t5 miss", {31'd0, busy}, 32'd1);
        run_refill(beats);
        check("t5 beats", 32'(beats), 32'd4);
        check("t5 data", read_data, 32'h11);

        // 6: flush mid-refill: word delivered, line left invalid.
        cycle(1'b1, 32'h44C, 1'b0, 1'b0);
        check("t6 miss", {31'd0, busy}, 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        run_refill(beats);
        check("t6 done", {31'd0, done}, 32'd1);
        check("t6 data", read_data, mem_word(32'h44C));
        cycle(1'b1, 32'h44C, 1'b0, 1'b0);
        check("t6 re-miss", {31'd0, busy}, 32'd1);
        run_refill(beats);

        // 7: rst on the 2nd mem_valid aborts the refill at once.
        cycle(1'b1, 32'h80, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        read_flag = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = mem_word(mem_addr);
        chk_en    = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t7 busy async", {31'd0, busy}, 32'd0);
        check("t7 mem_read async", {31'd0, mem_read}, 32'd0);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        mem_valid = 1'b0;
        chk_en    = 1'b1;
        cycle(1'b1, 32'h80, 1'b0, 1'b0);
        check("t7 miss", {31'd0, busy}, 32'd1);
        run_refill(beats);
        check("t7 beats", 32'(beats), 32'd4);
        check("t7 data", read_data, mem_word(32'h80));

        // Randomized phase: small tag/index pool to force hits and conflicts.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
                | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 1)));
        end
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
